// File: rtl/dnn_infer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dnn_infer_ctrl_if
//  Purpose  : Bundles every handshake and bus signal of dnn_infer_ctrl.
//             - pixel stream : img_valid, img_data, img_ready
//             - act. memory  : wr_en, wr_addr, wr_data
//             - engine ctrl  : eng_start, eng_reset, eng_done, eng_out[10]
//             - result       : res_valid, res_ready, res_class, res_score
//             - status       : busy, err_timeout
//             The master modport is the controller; the slave modport is
//             its environment (pixel source, memory, engine, result sink).
//  Revision : 1.0 - initial release
// ============================================================================
interface dnn_infer_ctrl_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 16
);
  logic                         img_valid;
  logic signed [DATA_WIDTH-1:0] img_data;
  logic                         img_ready;

  logic                         wr_en;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [DATA_WIDTH-1:0]        wr_data;

  logic                         eng_start;
  logic                         eng_reset;
  logic                         eng_done;
  logic signed [DATA_WIDTH-1:0] eng_out [10];

  logic                         res_valid;
  logic                         res_ready;
  logic [3:0]                   res_class;
  logic signed [DATA_WIDTH-1:0] res_score;

  logic                         busy;
  logic                         err_timeout;

  modport master (
    input  img_valid, img_data, eng_done, eng_out, res_ready,
    output img_ready, wr_en, wr_addr, wr_data, eng_start, eng_reset,
           res_valid, res_class, res_score, busy, err_timeout
  );

  modport slave (
    output img_valid, img_data, eng_done, eng_out, res_ready,
    input  img_ready, wr_en, wr_addr, wr_data, eng_start, eng_reset,
           res_valid, res_class, res_score, busy, err_timeout
  );
endinterface
`default_nettype wire

// File: rtl/dnn_infer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dnn_infer_ctrl
//  Purpose  : Sequencer around a 10-class inference engine. Streams one
//             image (NUM_PIX pixels) into activation memory, clears and
//             starts the engine, waits for eng_done (bounded by TIMEOUT),
//             then runs a 10-cycle signed argmax over the engine outputs
//             and presents {class, score} on a valid/ready handshake.
//  Ports    : clk, rst (sync, active high) and one dnn_infer_ctrl_if.master
//             carrying the pixel, memory-write, engine, result and status
//             signals.
//  Revision : 1.0 - initial release
// ============================================================================
module dnn_infer_ctrl #(
  parameter int                    DATA_WIDTH  = 6,
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = 16'h0000,
  parameter int                    NUM_PIX     = 400,
  parameter logic [19:0]           TIMEOUT     = 20'd1000000
) (
  input  logic                clk,
  input  logic                rst,
  dnn_infer_ctrl_if.master    bus
);

  localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [PIX_W-1:0] C_LAST_PIX = PIX_W'(NUM_PIX - 1);
  localparam logic [3:0]       C_LAST_IDX = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CLR    = 3'd2,
    S_START  = 3'd3,
    S_RUN    = 3'd4,
    S_ARGMAX = 3'd5,
    S_RESULT = 3'd6
  } state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic [PIX_W-1:0]             r_pix_cnt;
  logic [19:0]                  r_run_cnt;
  logic signed [DATA_WIDTH-1:0] r_lat [10];
  logic [3:0]                   r_idx;
  logic [3:0]                   r_best_idx;
  logic signed [DATA_WIDTH-1:0] r_best_val;
  logic                         r_err;

  logic w_ready;
  logic w_accept;
  logic w_last_pix;
  logic w_timeout;
  logic w_eng_start;
  logic w_eng_reset;
  logic w_res_valid;
  logic w_busy;

  // img_ready is forced low while rst is asserted, which also blocks writes.
  assign w_ready    = !rst && (r_state == S_IDLE || r_state == S_LOAD);
  assign w_accept   = bus.img_valid && w_ready;
  assign w_last_pix = (r_pix_cnt == C_LAST_PIX);
  // Abort on the TIMEOUT-th RUN cycle unless the engine finishes in it.
  assign w_timeout  = (r_state == S_RUN) && !bus.eng_done &&
                      (r_run_cnt == TIMEOUT - 20'd1);

  always_comb begin
    w_next      = r_state;
    w_eng_start = 1'b0;
    w_eng_reset = 1'b0;
    w_res_valid = 1'b0;
    w_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_accept) begin
          w_next = w_last_pix ? S_CLR : S_LOAD;
        end
      end
      S_CLR: begin
        w_eng_reset = 1'b1;
        w_next      = S_START;
      end
      S_START: begin
        w_eng_start = 1'b1;
        w_next      = S_RUN;
      end
      S_RUN: begin
        if (bus.eng_done) begin
          w_next = S_ARGMAX;
        end else if (w_timeout) begin
          w_eng_reset = 1'b1;
          w_next      = S_IDLE;
        end
      end
      S_ARGMAX: begin
        if (r_idx == C_LAST_IDX) begin
          w_next = S_RESULT;
        end
      end
      S_RESULT: begin
        w_res_valid = 1'b1;
        if (bus.res_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (rst) begin
      w_eng_start = 1'b0;
      w_eng_reset = 1'b0;
      w_res_valid = 1'b0;
      w_busy      = 1'b0;
      w_next      = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pix_cnt  <= '0;
      r_run_cnt  <= '0;
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_val <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_accept) begin
        r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
        r_err     <= 1'b0;
      end

      case (r_state)
        S_START: r_run_cnt <= '0;
        S_RUN: begin
          r_run_cnt <= r_run_cnt + 20'd1;
          r_idx     <= '0;
        end
        S_ARGMAX: begin
          r_idx <= r_idx + 4'd1;
          // Entry 0 seeds the scan; later entries win only when strictly
          // greater, so ties keep the lowest index.
          if (r_idx == 4'd0 || r_lat[r_idx] > r_best_val) begin
            r_best_val <= r_lat[r_idx];
            r_best_idx <= r_idx;
          end
        end
        default: ;
      endcase

      if (w_timeout) begin
        r_err <= 1'b1;
      end

      if (r_state != S_IDLE && w_next == S_IDLE) begin
        r_pix_cnt  <= '0;
        r_run_cnt  <= '0;
        r_best_idx <= '0;
        r_best_val <= '0;
      end
    end
  end

  // Engine outputs are pure datapath: only captured on the done cycle.
  always_ff @(posedge clk) begin
    if (r_state == S_RUN && bus.eng_done) begin
      for (int i = 0; i < 10; i++) begin
        r_lat[i] <= bus.eng_out[i];
      end
    end
  end

  assign bus.img_ready   = w_ready;
  assign bus.wr_en       = w_accept;
  assign bus.wr_addr     = ADDR_BASE_A + ADDR_WIDTH'(r_pix_cnt);
  assign bus.wr_data     = bus.img_data;
  assign bus.eng_start   = w_eng_start;
  assign bus.eng_reset   = w_eng_reset;
  assign bus.res_valid   = w_res_valid;
  assign bus.res_class   = r_best_idx;
  assign bus.res_score   = r_best_val;
  assign bus.busy        = w_busy;
  assign bus.err_timeout = r_err && !rst;

endmodule
`default_nettype wire

// File: tb/tb_dnn_infer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dnn_infer_ctrl
//  Purpose  : Self-checking bench for dnn_infer_ctrl (TIMEOUT set to 50).
//             Reset, timeout abort, mid-load reset and a table of argmax
//             vectors, each run as a full image load plus engine cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dnn_infer_ctrl;
  localparam int DW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dnn_infer_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(16)) bus ();

  dnn_infer_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (16),
    .ADDR_BASE_A(16'h0000),
    .NUM_PIX    (400),
    .TIMEOUT    (20'd50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic signed [DW-1:0] e [10];
    int                   cls;
    int                   score;
    int                   stall;
    bit                   gaps;
  } vec_t;

  vec_t vecs [5];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wr_count = 0;

  always @(negedge clk) if (bus.wr_en === 1'b1) wr_count++;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pix(input int i);
    return DW'((i + 5) % 64);
  endfunction

  // Feeds pixels first..last_excl-1; returns in the cycle of the last accept.
  task automatic load_image(input int first, input int last_excl, input bit gaps);
    int i;
    int guard;
    i = first;
    guard = 0;
    while (i < last_excl && guard < 4000) begin
      tick();
      bus.img_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.img_data  = pix(i);
      #1;
      check("img_ready_load", bus.img_ready, 1);
      check("wr_en_load", bus.wr_en, bus.img_valid);
      if (bus.img_valid) begin
        check("wr_addr", bus.wr_addr, i);
        check("wr_data", bus.wr_data, pix(i));
        i++;
      end
      guard++;
    end
    if (i < last_excl) check("load_guard", i, last_excl);
  endtask

  // CLR and START pulses; returns in the first RUN cycle.
  task automatic clr_start();
    tick();
    bus.img_valid = 1'b0;
    #1;
    check("clr_eng_reset", bus.eng_reset, 1);
    check("clr_eng_start", bus.eng_start, 0);
    check("clr_img_ready", bus.img_ready, 0);
    check("clr_busy", bus.busy, 1);
    tick();
    #1;
    check("start_eng_start", bus.eng_start, 1);
    check("start_eng_reset", bus.eng_reset, 0);
    tick();
    #1;
    check("run_eng_start", bus.eng_start, 0);
    check("run_busy", bus.busy, 1);
  endtask

  task automatic run_vec(input int v);
    int k;
    clr_start();
    tick();
    tick();
    for (int j = 0; j < 10; j++) bus.eng_out[j] = vecs[v].e[j];
    bus.eng_done = 1'b1;
    #1;
    k = 0;
    do begin
      tick();
      bus.eng_done = 1'b0;
      #1;
      k++;
    end while (bus.res_valid !== 1'b1 && k < 30);
    check("latency", k, 11);
    check("res_class", bus.res_class, vecs[v].cls);
    check("res_score", bus.res_score, vecs[v].score);
    for (int s = 0; s < vecs[v].stall; s++) begin
      tick();
      bus.res_ready = 1'b0;
      bus.eng_done  = (s == 2);
      for (int j = 0; j < 10; j++) bus.eng_out[j] = 6'sd31;
      #1;
      check("stall_valid", bus.res_valid, 1);
      check("stall_class", bus.res_class, vecs[v].cls);
      check("stall_score", bus.res_score, vecs[v].score);
    end
    tick();
    bus.eng_done  = 1'b0;
    bus.res_ready = 1'b1;
    #1;
    check("hs_valid", bus.res_valid, 1);
    tick();
    bus.res_ready = 1'b0;
    #1;
    check("post_valid", bus.res_valid, 0);
    check("post_busy", bus.busy, 0);
    check("post_img_ready", bus.img_ready, 1);
    check("post_score_clr", bus.res_score, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    bus.img_valid = 1'b0;
    bus.img_data  = '0;
    bus.eng_done  = 1'b0;
    bus.res_ready = 1'b0;
    for (int j = 0; j < 10; j++) bus.eng_out[j] = '0;

    vecs[0].e = '{3, -2, 7, 7, 0, 1, -32, 6, 2, 7};
    vecs[0].cls = 2; vecs[0].score = 7; vecs[0].stall = 20; vecs[0].gaps = 1'b1;
    vecs[1].e = '{-32, -32, -32, -32, -32, -32, -32, -32, -32, -32};
    vecs[1].cls = 0; vecs[1].score = -32; vecs[1].stall = 3; vecs[1].gaps = 1'b0;
    vecs[2].e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 31};
    vecs[2].cls = 9; vecs[2].score = 31; vecs[2].stall = 4; vecs[2].gaps = 1'b1;
    vecs[3].e = '{-3, -4, -9, -2, -9, -10, -2, -5, -6, -7};
    vecs[3].cls = 3; vecs[3].score = -2; vecs[3].stall = 0; vecs[3].gaps = 1'b0;
    vecs[4].e = '{-32, -1, -32, -32, -32, -32, -32, -32, -32, -32};
    vecs[4].cls = 1; vecs[4].score = -1; vecs[4].stall = 5; vecs[4].gaps = 1'b1;

    // Reset state, with img_valid already high.
    tick();
    bus.img_valid = 1'b1;
    #1;
    check("rst_img_ready", bus.img_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_eng_start", bus.eng_start, 0);
    check("rst_eng_reset", bus.eng_reset, 0);
    check("rst_err", bus.err_timeout, 0);
    tick();
    rst = 1'b0;
    bus.img_valid = 1'b0;
    #1;
    check("idle_img_ready", bus.img_ready, 1);
    check("idle_busy", bus.busy, 0);
    check("idle_class", bus.res_class, 0);
    check("idle_score", bus.res_score, 0);

    // Back-to-back load, then engine never finishes: timeout abort.
    base = wr_count;
    load_image(0, 400, 1'b0);
    clr_start();
    for (int k = 1; k <= 50; k++) begin
      if (k > 1) tick();
      #1;
      check("to_eng_reset", bus.eng_reset, (k == 50) ? 1 : 0);
      check("to_res_valid", bus.res_valid, 0);
      check("to_err_early", bus.err_timeout, 0);
    end
    tick();
    #1;
    check("to_err", bus.err_timeout, 1);
    check("to_busy", bus.busy, 0);
    check("to_eng_reset_off", bus.eng_reset, 0);
    check("to_res_valid_idle", bus.res_valid, 0);
    check("to_writes", wr_count - base, 400);
    tick();
    #1;
    check("to_err_held", bus.err_timeout, 1);

    // First accept of the next image clears err_timeout; reset at pixel 137.
    tick();
    bus.img_valid = 1'b1;
    bus.img_data  = pix(0);
    #1;
    check("reload_addr0", bus.wr_addr, 0);
    check("err_until_accept", bus.err_timeout, 1);
    load_image(1, 137, 1'b1);
    check("err_cleared", bus.err_timeout, 0);
    tick();
    rst = 1'b1;
    bus.img_valid = 1'b1;
    bus.img_data  = pix(137);
    #1;
    check("midrst_wr_en", bus.wr_en, 0);
    check("midrst_img_ready", bus.img_ready, 0);
    check("midrst_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    bus.img_valid = 1'b0;
    #1;
    check("midrst_idle_busy", bus.busy, 0);
    check("midrst_idle_ready", bus.img_ready, 1);
    check("midrst_idle_wr_en", bus.wr_en, 0);

    // Argmax table; each image reloads from address 0.
    for (int v = 0; v < 5; v++) begin
      base = wr_count;
      load_image(0, 400, vecs[v].gaps);
      run_vec(v);
      check("write_count", wr_count - base, 400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
